// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) definitions for the encoder/decoder pair.
//   CODE_W / DATA_W / SYN_W : codeword, data and syndrome widths
//   *_IDX                   : codeword bit index of each Hamming position (bit k-1 = position k)
//   ham_syndrome()          : 3-bit syndrome {s3,s2,s1}; value = erroneous position, 0 = clean
//   ham_extract()           : pulls {d4,d3,d2,d1} out of a codeword
//   ham_dec_word_t          : one decoded result as held in the output stage
package ham_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;

  localparam int unsigned P1_IDX = 0;
  localparam int unsigned P2_IDX = 1;
  localparam int unsigned D1_IDX = 2;
  localparam int unsigned P3_IDX = 3;
  localparam int unsigned D2_IDX = 4;
  localparam int unsigned D3_IDX = 5;
  localparam int unsigned D4_IDX = 6;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
    logic [SYN_W-1:0]  syn;
  } ham_dec_word_t;

  function automatic logic [SYN_W-1:0] ham_syndrome(input logic [CODE_W-1:0] code);
    logic [SYN_W-1:0] syn;
    syn[0] = code[P1_IDX] ^ code[D1_IDX] ^ code[D2_IDX] ^ code[D4_IDX];
    syn[1] = code[P2_IDX] ^ code[D1_IDX] ^ code[D3_IDX] ^ code[D4_IDX];
    syn[2] = code[P3_IDX] ^ code[D2_IDX] ^ code[D3_IDX] ^ code[D4_IDX];
    return syn;
  endfunction

  function automatic logic [DATA_W-1:0] ham_extract(input logic [CODE_W-1:0] code);
    return {code[D4_IDX], code[D3_IDX], code[D2_IDX], code[D1_IDX]};
  endfunction

endpackage

// File: rtl/ham_decoder_pipe_if.sv
// Stream bus of the Hamming(7,4) decoder.
//   in_valid/in_ready/in_code        : codeword input handshake
//   out_valid/out_ready/out_data/
//   out_err/out_syn                  : decoded result handshake
//   out_dpar                         : data parity, only with HAM_DEC_DATA_PARITY_EN defined
// Modports: slave = the decoder, master = the environment driving/consuming it.
interface ham_decoder_pipe_if;
  import ham_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic [SYN_W-1:0]  out_syn;
`ifdef HAM_DEC_DATA_PARITY_EN
  logic              out_dpar;

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_err, out_syn, out_dpar
  );
  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_syn, out_dpar
  );
`else
  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_err, out_syn
  );
  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_syn
  );
`endif

endinterface

// File: rtl/ham_correct.sv
// Combinational single-error corrector for Hamming(7,4).
//   code_i : received codeword
//   syn_i  : its syndrome (erroneous position, 0 = clean)
//   data_o : corrected data {d4,d3,d2,d1}
// A parity-position syndrome flips a parity bit, so data passes through unchanged.
module ham_correct
  import ham_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic [SYN_W-1:0]  syn_i,
  output logic [DATA_W-1:0] data_o
);

  logic [CODE_W-1:0] flip;
  logic [CODE_W-1:0] fixed;

  always_comb begin
    flip = '0;
    // Position k lives at bit k-1; syndrome 0 leaves the mask empty.
    for (int k = 0; k < CODE_W; k++) begin
      flip[k] = (syn_i == SYN_W'(k + 1));
    end
    fixed  = code_i ^ flip;
    data_o = ham_extract(fixed);
  end

endmodule

// File: rtl/ham_decoder_pipe.sv
// Streaming Hamming(7,4) decoder, two registered stages.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : ham_decoder_pipe_if.slave (codeword in, decoded data/err/syndrome out)
//   cnt_clr  : synchronous clear of err_cnt (wins over an increment)
//   err_cnt  : saturating count of delivered words that carried a correction
// S1 captures the codeword and its syndrome; S2 applies the correction and is the
// output register. Holds at most two words; full throughput when out_ready stays high.
// Optional HAM_DEC_DATA_PARITY_EN adds bus.out_dpar = XOR of the corrected data.
module ham_decoder_pipe
  import ham_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  ham_decoder_pipe_if.slave bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic              v1_q, v1_d;
  logic [CODE_W-1:0] code1_q, code1_d;
  logic [SYN_W-1:0]  syn1_q, syn1_d;

  logic              v2_q, v2_d;
  ham_dec_word_t     out_q, out_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              adv2;
  logic              accept;
  logic              out_xfer;
  logic [DATA_W-1:0] corr_data;

  ham_correct u_correct (
    .code_i (code1_q),
    .syn_i  (syn1_q),
    .data_o (corr_data)
  );

  // S2 can take a new word when empty or when its current word leaves this cycle.
  assign adv2         = ~v2_q | bus.out_ready;
  assign bus.in_ready = ~v1_q | adv2;
  assign accept       = bus.in_valid & bus.in_ready;
  assign out_xfer     = v2_q & bus.out_ready;

  always_comb begin
    code1_d = code1_q;
    syn1_d  = syn1_q;
    v2_d    = v2_q;
    out_d   = out_q;
    cnt_d   = cnt_q;

    if (accept) begin
      code1_d = bus.in_code;
      syn1_d  = ham_syndrome(bus.in_code);
    end
    // S1 stays full only if it held a word that could not move on.
    v1_d = accept | (v1_q & ~adv2);

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        out_d.data = corr_data;
        out_d.err  = (syn1_q != '0);
        out_d.syn  = syn1_q;
      end
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_xfer && out_q.err && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      code1_q <= '0;
      syn1_q  <= '0;
      v2_q    <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      code1_q <= code1_d;
      syn1_q  <= syn1_d;
      v2_q    <= v2_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAM_DEC_DATA_PARITY_EN
  logic dpar_q, dpar_d;

  always_comb begin
    dpar_d = dpar_q;
    if (adv2 && v1_q) begin
      dpar_d = ^corr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dpar_q <= 1'b0;
    end else begin
      dpar_q <= dpar_d;
    end
  end

  assign bus.out_dpar = dpar_q;
`endif

  assign bus.out_valid = v2_q;
  assign bus.out_data  = out_q.data;
  assign bus.out_err   = out_q.err;
  assign bus.out_syn   = out_q.syn;
  assign err_cnt       = cnt_q;

endmodule

// File: tb/tb_ham_decoder_pipe.sv
// Bench for ham_decoder_pipe: a CNT_W=2 instance carries the checks, a CNT_W=8 instance
// sees identical stimulus so the unsaturated count is observed too.
module tb_ham_decoder_pipe;
  import ham_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cnt_clr;
  logic [1:0] err_cnt2;
  logic [7:0] err_cnt8;

  ham_decoder_pipe_if ifc ();
  ham_decoder_pipe_if if8 ();

  assign if8.in_valid  = ifc.in_valid;
  assign if8.in_code   = ifc.in_code;
  assign if8.out_ready = ifc.out_ready;

  ham_decoder_pipe #(.CNT_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (ifc),
    .cnt_clr (cnt_clr),
    .err_cnt (err_cnt2)
  );

  ham_decoder_pipe #(.CNT_W(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .bus     (if8),
    .cnt_clr (cnt_clr),
    .err_cnt (err_cnt8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       err;
    logic [2:0] syn;
    int         t;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   cnt2_m   = 0;
  int   cnt8_m   = 0;

  // Reference: syndrome = XOR of the positions (1..7) whose bit is set.
  function automatic exp_t model(input logic [6:0] c, input int t);
    exp_t e;
    int s;
    logic [6:0] f;
    s = 0;
    for (int k = 1; k <= 7; k++) if (c[k-1]) s = s ^ k;
    f = c;
    if (s != 0) f[s-1] = ~f[s-1];
    e.data = {f[6], f[5], f[4], f[2]};
    e.err  = (s != 0);
    e.syn  = s[2:0];
    e.t    = t;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check against the model, advance the model.
  task automatic step(input logic iv, input logic [6:0] code, input logic ordy,
                      input logic clr, output logic acc);
    logic rdy_e, ov_e, xfer;
    @(negedge clk);
    ifc.in_valid  = iv;
    ifc.in_code   = code;
    ifc.out_ready = ordy;
    cnt_clr       = clr;
    #1;
    rdy_e = (q.size() < 2) || ordy;
    ov_e  = (q.size() > 0) && (q[0].t < cyc);
    chk("in_ready", 32'(ifc.in_ready), 32'(rdy_e));
    chk("out_valid", 32'(ifc.out_valid), 32'(ov_e));
    chk("out_valid8", 32'(if8.out_valid), 32'(ov_e));
    chk("err_cnt2", 32'(err_cnt2), 32'(cnt2_m));
    chk("err_cnt8", 32'(err_cnt8), 32'(cnt8_m));
    if (ov_e) begin
      chk("out_data", 32'(ifc.out_data), 32'(q[0].data));
      chk("out_err", 32'(ifc.out_err), 32'(q[0].err));
      chk("out_syn", 32'(ifc.out_syn), 32'(q[0].syn));
`ifdef HAM_DEC_DATA_PARITY_EN
      chk("out_dpar", 32'(ifc.out_dpar), 32'(^q[0].data));
`endif
    end
    acc  = iv && rdy_e;
    xfer = ov_e && ordy;
    if (clr) begin
      cnt2_m = 0;
      cnt8_m = 0;
    end else if (xfer && q[0].err) begin
      if (cnt2_m < 3) cnt2_m++;
      if (cnt8_m < 255) cnt8_m++;
    end
    if (xfer) void'(q.pop_front());
    if (acc) q.push_back(model(code, cyc + 1));
    @(posedge clk);
    cyc++;
  endtask

  // Explicit known-answer check of the word sitting in the output stage.
  task automatic expect_out(input string tag, input logic [3:0] d, input logic e,
                            input logic [2:0] s);
    #2;
    chk({tag, "_valid"}, 32'(ifc.out_valid), 32'(1));
    chk({tag, "_data"}, 32'(ifc.out_data), 32'(d));
    chk({tag, "_err"}, 32'(ifc.out_err), 32'(e));
    chk({tag, "_syn"}, 32'(ifc.out_syn), 32'(s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a;
    int         tries;
    logic [6:0] cw_clean;
    logic [6:0] cw_derr;
    logic [6:0] cw_perr;
    cw_clean = 7'b1010101;
    cw_derr  = 7'b1010001;
    cw_perr  = 7'b1010100;

    ifc.in_valid  = 1'b0;
    ifc.in_code   = '0;
    ifc.out_ready = 1'b0;
    cnt_clr       = 1'b0;
    rst           = 1'b1;
    #12;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'(0));
    chk("rst_out_data", 32'(ifc.out_data), 32'(0));
    chk("rst_out_err", 32'(ifc.out_err), 32'(0));
    chk("rst_out_syn", 32'(ifc.out_syn), 32'(0));
    chk("rst_err_cnt", 32'(err_cnt2), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(ifc.in_ready), 32'(1));

    // Clean, data-bit error, parity-bit error.
    step(1'b1, cw_clean, 1'b1, 1'b0, a);
    step(1'b0, 7'h00, 1'b1, 1'b0, a);
    expect_out("clean", 4'b1011, 1'b0, 3'b000);
    step(1'b1, cw_derr, 1'b1, 1'b0, a);
    step(1'b0, 7'h00, 1'b1, 1'b0, a);
    expect_out("derr", 4'b1011, 1'b1, 3'b011);
    step(1'b1, cw_perr, 1'b1, 1'b0, a);
    step(1'b0, 7'h00, 1'b1, 1'b0, a);
    expect_out("perr", 4'b1011, 1'b1, 3'b001);
    step(1'b0, 7'h00, 1'b1, 1'b0, a);
    step(1'b0, 7'h00, 1'b1, 1'b0, a);
    chk("cnt_after_two_err", 32'(err_cnt2), 32'(2));

    // Backpressure: two accepts, then in_ready low while out_ready is held off.
    step(1'b1, cw_clean, 1'b0, 1'b0, a);
    step(1'b1, cw_derr, 1'b0, 1'b0, a);
    for (int i = 0; i < 3; i++) step(1'b1, 7'b0000000, 1'b0, 1'b0, a);
    tries = 0;
    do begin
      step(1'b1, 7'b0000000, 1'b1, 1'b0, a);
      tries++;
    end while (!a && tries < 5);
    chk("bp_third_accepted", 32'(a), 32'(1));
    for (int i = 0; i < 3; i++) step(1'b0, 7'h00, 1'b1, 1'b0, a);

    // Saturation on the 2-bit counter, then clear racing an errored transfer.
    for (int i = 0; i < 5; i++) step(1'b1, cw_derr, 1'b1, 1'b0, a);
    for (int i = 0; i < 3; i++) step(1'b0, 7'h00, 1'b1, 1'b0, a);
    chk("sat_cnt2", 32'(err_cnt2), 32'(3));
    chk("sat_cnt8", 32'(err_cnt8), 32'(8));
    step(1'b1, cw_derr, 1'b1, 1'b0, a);
    step(1'b0, 7'h00, 1'b1, 1'b0, a);
    step(1'b0, 7'h00, 1'b1, 1'b1, a);
    step(1'b0, 7'h00, 1'b1, 1'b0, a);
    chk("clr_cnt2", 32'(err_cnt2), 32'(0));
    chk("clr_cnt8", 32'(err_cnt8), 32'(0));

    // Async reset with both stages full and a non-zero count.
    step(1'b1, cw_derr, 1'b1, 1'b0, a);
    step(1'b0, 7'h00, 1'b1, 1'b0, a);
    step(1'b0, 7'h00, 1'b1, 1'b0, a);
    step(1'b1, cw_clean, 1'b0, 1'b0, a);
    step(1'b1, cw_derr, 1'b0, 1'b0, a);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(ifc.out_valid), 32'(0));
    chk("arst_err_cnt2", 32'(err_cnt2), 32'(0));
    chk("arst_err_cnt8", 32'(err_cnt8), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    cnt2_m = 0;
    cnt8_m = 0;
    #1;
    chk("arst_in_ready", 32'(ifc.in_ready), 32'(1));
    step(1'b1, cw_perr, 1'b1, 1'b0, a);
    step(1'b0, 7'h00, 1'b1, 1'b0, a);
    expect_out("post_rst", 4'b1011, 1'b1, 3'b001);
    step(1'b0, 7'h00, 1'b1, 1'b0, a);

    // Random traffic with random stalls and occasional clears.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 7'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, a);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 7'h00, 1'b1, 1'b0, a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
